reorder_buffer_param: RTL
=========================

Name: reorder_buffer_param

Overview:
- Parametrised reorder buffer (ROB) for the Tomasulo core.
- Accepts in-order allocations from issue and captures results from NUM_CDB common-data-bus channels out of order.
- Retires entries in order to the register bank and flushes all speculative state when a mispredicted branch commits.
- Replaces the fixed 8-entry, single-bus ROB array with a configurable depth, data width and CDB channel count, and adds back-pressure, a tag read port and flush.

Parameters:
- DEPTH, 8, number of entries; power of 2, at least 2.
- TAG_W, $clog2(DEPTH), width of an ROB tag.
- DATA_W, 16, width of a result value.
- REG_W, 4, architectural register index width (16 registers).
- NUM_CDB, 2, number of result-broadcast channels.

Ports:
- clk1  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  issue requests a new entry.
- alloc_ready  out  1  ROB can accept an allocation.
- alloc_dest  in  REG_W  destination register of the issuing instruction.
- alloc_is_branch  in  1  issuing instruction is a branch.
- alloc_tag  out  TAG_W  tag given to this allocation; equals tail.
- cdb_valid  in  NUM_CDB  per-channel result valid.
- cdb_tag  in  NUM_CDB*TAG_W  per-channel ROB tag; channel i uses bits [i*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  per-channel result value.
- cdb_mispredict  in  NUM_CDB  branch outcome mispredicted; meaningful only for branch entries.
- rd_tag  in  TAG_W  operand lookup tag for issue.
- rd_done  out  1  the looked-up entry holds its result.
- rd_data  out  DATA_W  result of the looked-up entry.
- commit_valid  out  1  head entry is ready to retire.
- commit_ready  in  1  register bank accepts the retirement.
- commit_dest  out  REG_W  head destination register.
- commit_data  out  DATA_W  head result value.
- commit_tag  out  TAG_W  head tag.
- flush  out  1  one-cycle pulse after a mispredicted branch retires.
- count  out  TAG_W+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Entry state is FREE, ISSUED or DONE. Each entry also holds dest, data, is_branch and mispredict.
- Reset, asynchronous while rst_n=0:
  - all entries FREE; head=tail=0; count=0.
  - flush=0, commit_valid=0, empty=1, full=0, alloc_ready=1, rd_done=0.
- Reset mid-operation discards every entry with no commit.
- Allocation:
  - occurs when alloc_valid && alloc_ready. Entry[tail] becomes ISSUED, and tail increments modulo DEPTH on the next edge.
  - alloc_ready = !full && !flush_pending.
  - There is no bypass: a simultaneous commit does not free a slot for allocation in the same cycle.
- CDB capture:
  - on a cdb_valid[i] hit to an ISSUED entry, the entry becomes DONE, data is latched, and mispredict is latched (only if is_branch).
  - A hit to a FREE or DONE entry is ignored.
  - If two channels carry the same tag, the lowest index wins.
  - An entry becomes DONE no earlier than the edge after the broadcast.
- Commit:
  - commit_valid = entry[head] is DONE. commit_* outputs are combinational from head registers.
  - On commit_valid && commit_ready, entry[head] becomes FREE and head increments modulo DEPTH.
  - A result captured into the head entry is committable one cycle later. Latency from broadcast to commit_valid is 1 cycle.
- count/full/empty:
  - count is +1 on allocation, -1 on commit, and unchanged when both occur.
  - full and empty are derived from count, so head==tail is unambiguous.
- Read port:
  - rd_done/rd_data reflect entry[rd_tag] when it is DONE.
  - A same-cycle CDB hit on rd_tag is forwarded combinationally, lowest channel first.
  - rd_done=0 for FREE and ISSUED entries.
- Flush:
  - flush_pending is true when the head is a DONE branch with mispredict=1. It holds alloc_ready low.
  - Committing that branch writes it out normally (commit_dest/data valid).
  - On the next edge all entries become FREE, head=tail=0, count=0, and flush=1 for exactly one cycle.
  - CDB writes in the flush cycle are ignored.
- Wrap-around: head and tail roll from DEPTH-1 to 0 with no bubble.

Decomposition:
- Package tomasulo_pkg holds:
  - the entry state enum (FREE/ISSUED/DONE);
  - default DEPTH, DATA_W, REG_W and NUM_CDB;
  - the rob_entry_t struct (state, dest, data, is_branch, mispredict).
- One sub-module: rob_cdb_match. It is instantiated per entry and for the read port. It takes cdb_valid/tag/data and a target tag and returns hit plus the priority-selected data (lowest channel wins).

Test Plan:
- Reset with DEPTH=8: allocate 8 with alloc_dest=1..8 → alloc_tag 0..7, full=1, alloc_ready=0, count=8; a 9th alloc_valid is not accepted.
- Out-of-order completion: tags 0,1,2 allocated; CDB writes tag2=0x30, then tag0=0x10, then tag1=0x20 → commits occur in order 0,1,2 with data 0x10, 0x20, 0x30. commit_valid first rises one cycle after the tag0 write.
- Dual CDB: same cycle ch0 tag3=0xAA and ch1 tag3=0xBB → entry3 data 0xAA. Same cycle ch0 tag4 and ch1 tag5 → both entries become DONE.
- Read-port forwarding: rd_tag=2 while entry2 is ISSUED and ch1 broadcasts tag2=0x55 → rd_done=1 and rd_data=0x55 that cycle. rd_tag pointing at a FREE entry → rd_done=0.
- Mispredict flush: branch at tag1, younger tags 2 and 3 DONE; tag1 written with mispredict=1 → tag1 commits; next cycle flush=1, count=0, empty=1, and tags 2 and 3 never commit. The next allocation returns alloc_tag=0.
- Wrap and reset: fill/drain 20 entries with commit_ready toggled each cycle → tags wrap 7→0 and count never exceeds 8. Asserting rst_n=0 mid-stream → all outputs are at reset values immediately, before the next clk1 edge.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types and default geometry for the Tomasulo reorder buffer.
package tomasulo_pkg;

    localparam int unsigned ROB_DEPTH   = 8;
    localparam int unsigned ROB_DATA_W  = 16;
    localparam int unsigned ROB_REG_W   = 4;
    localparam int unsigned ROB_NUM_CDB = 2;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_DONE   = 2'd2
    } rob_state_e;

    // Entry layout at the default geometry; the ROB mirrors it with its own widths.
    typedef struct packed {
        rob_state_e              state;
        logic [ROB_REG_W-1:0]    dest;
        logic [ROB_DATA_W-1:0]   data;
        logic                    is_branch;
        logic                    mispredict;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_param_cdb_match.sv
// Compares every CDB channel against one ROB tag; lowest channel index wins.
module rob_cdb_match #(
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DW      = 16
) (
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*DW-1:0]    cdb_data,
    input  logic [TAG_W-1:0]         target,
    output logic                     hit,
    output logic [DW-1:0]            data
);

    // Scan from the highest channel down so the lowest matching channel is kept last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == target)) begin
                hit  = 1'b1;
                data = cdb_data[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order CDB capture,
// in-order retire, full flush after a mispredicted branch retires.
module reorder_buffer_param
    import tomasulo_pkg::*;
#(
    parameter int unsigned DEPTH   = ROB_DEPTH,
    parameter int unsigned TAG_W   = $clog2(DEPTH),
    parameter int unsigned DATA_W  = ROB_DATA_W,
    parameter int unsigned REG_W   = ROB_REG_W,
    parameter int unsigned NUM_CDB = ROB_NUM_CDB
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [REG_W-1:0]          alloc_dest,
    input  logic                      alloc_is_branch,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    input  logic [NUM_CDB-1:0]        cdb_mispredict,
    input  logic [TAG_W-1:0]          rd_tag,
    output logic                      rd_done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [REG_W-1:0]          commit_dest,
    output logic [DATA_W-1:0]         commit_data,
    output logic [TAG_W-1:0]          commit_tag,
    output logic                      flush,
    output logic [TAG_W:0]            count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PAY_W = DATA_W + 1;

    typedef struct packed {
        rob_state_e          state;
        logic [REG_W-1:0]    dest;
        logic [DATA_W-1:0]   data;
        logic                is_branch;
        logic                mispredict;
    } entry_t;

    entry_t                   entries [DEPTH];
    logic [TAG_W-1:0]         head;
    logic [TAG_W-1:0]         tail;

    logic [NUM_CDB*PAY_W-1:0] cdb_payload;
    logic [DEPTH-1:0]         hit_e;
    logic [PAY_W-1:0]         hit_payload [DEPTH];
    logic                     rd_hit;
    logic [DATA_W-1:0]        rd_fwd_data;

    entry_t                   head_e;
    entry_t                   rd_e;
    logic                     flush_pending;
    logic                     alloc_fire;
    logic                     commit_fire;
    logic                     flush_commit;

    // Bundle each channel's mispredict bit above its data so one matcher returns both.
    always_comb begin
        cdb_payload = '0;
        for (int i = 0; i < int'(NUM_CDB); i++) begin
            cdb_payload[i*PAY_W +: PAY_W] = {cdb_mispredict[i], cdb_data[i*DATA_W +: DATA_W]};
        end
    end

    for (genvar e = 0; e < int'(DEPTH); e++) begin : g_entry
        rob_cdb_match #(
            .NUM_CDB (NUM_CDB),
            .TAG_W   (TAG_W),
            .DW      (PAY_W)
        ) u_match (
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_data  (cdb_payload),
            .target    (TAG_W'(e)),
            .hit       (hit_e[e]),
            .data      (hit_payload[e])
        );
    end

    rob_cdb_match #(
        .NUM_CDB (NUM_CDB),
        .TAG_W   (TAG_W),
        .DW      (DATA_W)
    ) u_rd_match (
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .target    (rd_tag),
        .hit       (rd_hit),
        .data      (rd_fwd_data)
    );

    // Handshakes, status flags and head-entry commit view.
    always_comb begin
        head_e        = entries[head];
        flush_pending = (head_e.state == ST_DONE) && head_e.is_branch && head_e.mispredict;
        full          = (count == (TAG_W+1)'(DEPTH));
        empty         = (count == '0);
        alloc_ready   = !full && !flush_pending;
        alloc_tag     = tail;
        alloc_fire    = alloc_valid && alloc_ready;
        commit_valid  = (head_e.state == ST_DONE);
        commit_dest   = head_e.dest;
        commit_data   = head_e.data;
        commit_tag    = head;
        commit_fire   = commit_valid && commit_ready;
        flush_commit  = commit_fire && flush_pending;
    end

    // Operand read port with same-cycle forwarding from the CDB into ISSUED entries.
    always_comb begin
        rd_e    = entries[rd_tag];
        rd_done = 1'b0;
        rd_data = '0;
        if (rd_e.state == ST_DONE) begin
            rd_done = 1'b1;
            rd_data = rd_e.data;
        end else if ((rd_e.state == ST_ISSUED) && rd_hit) begin
            rd_done = 1'b1;
            rd_data = rd_fwd_data;
        end
    end

    // Entry array, pointers, occupancy and the one-cycle flush pulse.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                entries[e] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            flush <= 1'b0;
        end else if (flush_commit) begin
            // The mispredicted branch retires this cycle; everything younger is dropped.
            for (int e = 0; e < int'(DEPTH); e++) begin
                entries[e] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            flush <= 1'b1;
        end else begin
            flush <= 1'b0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (hit_e[e] && (entries[e].state == ST_ISSUED)) begin
                    entries[e].state      <= ST_DONE;
                    entries[e].data       <= hit_payload[e][DATA_W-1:0];
                    entries[e].mispredict <= entries[e].is_branch & hit_payload[e][DATA_W];
                end
                if (alloc_fire && (tail == TAG_W'(e))) begin
                    entries[e].state      <= ST_ISSUED;
                    entries[e].dest       <= alloc_dest;
                    entries[e].data       <= '0;
                    entries[e].is_branch  <= alloc_is_branch;
                    entries[e].mispredict <= 1'b0;
                end
                if (commit_fire && (head == TAG_W'(e))) begin
                    entries[e].state <= ST_FREE;
                end
            end
            if (alloc_fire) begin
                tail <= tail + TAG_W'(1);
            end
            if (commit_fire) begin
                head <= head + TAG_W'(1);
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
